// File: rtl/rr_mux_pkg.sv
// Shared parameters and state encoding for the round-robin mux arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rr_mux_pkg;

    // Default configuration of the shared N:1 mux datapath
    localparam int RR_N        = 8;
    localparam int RR_SELW     = 3;
    localparam int RR_WIDTH    = 1;
    localparam int RR_MAX_HOLD = 4;

    // Arbiter FSM: IDLE waits for any request, GRANT owns the datapath
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Bits needed for a hold counter that counts 0 .. max_hold-1
    function automatic int hold_width(input int max_hold);
        return (max_hold < 2) ? 1 : $clog2(max_hold);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating-priority picker: first set request at or after base, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request bit is set.
module rr_pick #(
    parameter int N    = 8,
    parameter int SELW = 3
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] base,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest set bit wins last;
    // N is a power of two so the SELW-bit add wraps mod N for free.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = base + SELW'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 mux scheduler with bounded hold; forwards the granted lane.
// Latency: grant registered one edge after request; data_out combinational.
// Backpressure: a requester is released after MAX_HOLD cycles or when it drops req.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N        = RR_N,
    parameter int SELW     = RR_SELW,
    parameter int WIDTH    = RR_WIDTH,
    parameter int MAX_HOLD = RR_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data_in,
    output logic [N-1:0]         gnt,
    output logic [SELW-1:0]      sel,
    output logic                 valid,
    output logic [WIDTH-1:0]     data_out
);

    localparam int             HW        = hold_width(MAX_HOLD);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [HW-1:0]   hold_cnt;

    logic [SELW-1:0] pick_base;
    logic [SELW-1:0] pick_idx;
    logic            pick_found;
    logic [N-1:0]    pick_oh;
    logic            release_now;

    // Grant ends when the owner drops its request or its hold budget is spent
    always_comb begin
        release_now = (state == ST_GRANT) &&
                      (!req[sel] || (hold_cnt == HOLD_LAST));
    end

    // While granted, the next winner is searched from sel+1 so the current
    // owner is considered last; in IDLE the stored priority pointer is used.
    always_comb begin
        pick_base = (state == ST_GRANT) ? (sel + SELW'(1)) : ptr;
    end

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req   (req),
        .base  (pick_base),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // One-hot form of the picked index for the registered grant vector
    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    // Arbiter FSM with registered grant, select, valid and hold counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            valid    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state    <= ST_GRANT;
                        gnt      <= pick_oh;
                        sel      <= pick_idx;
                        valid    <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        ptr      <= sel + SELW'(1);
                        hold_cnt <= '0;
                        if (pick_found) begin
                            // Back-to-back handover, possibly to the same owner
                            gnt   <= pick_oh;
                            sel   <= pick_idx;
                            valid <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                            sel   <= '0;
                            valid <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    gnt      <= '0;
                    sel      <= '0;
                    valid    <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Selected lane passes straight through; forced to zero when idle
    always_comb begin
        data_out = data_in[sel*WIDTH +: WIDTH] & {WIDTH{valid}};
    end

endmodule
